// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_pkg
// Brief   : Shared types and defaults for the register-file write-back path.
// Revision: 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

  localparam int ADW_DEF = 5;
  localparam int DPW_DEF = 32;

  // One buffered write: destination register and the data to store there.
  typedef struct packed {
    logic [ADW_DEF-1:0] rd;
    logic [DPW_DEF-1:0] wd;
  } wb_entry_t;

  // Producer identity; LSU wins arbitration.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage : rf_wb_pkg
`default_nettype wire

// File: rtl/rf_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback_if
// Brief   : Producer handshakes, register-file write port and hazard query
//           bundle for rf_writeback.
// Revision: 1.0 - initial release
// ============================================================================
interface rf_writeback_if
  import rf_wb_pkg::*;
#(
  parameter int ADW   = ADW_DEF,
  parameter int DPW   = DPW_DEF,
  parameter int DEPTH = 4
) ();

  // ALU producer
  logic                       alu_valid_i;
  logic                       alu_ready_o;
  logic [ADW-1:0]             alu_rd_i;
  logic [DPW-1:0]             alu_wd_i;
  // LSU producer
  logic                       lsu_valid_i;
  logic                       lsu_ready_o;
  logic [ADW-1:0]             lsu_rd_i;
  logic [DPW-1:0]             lsu_wd_i;
  // Register file write port
  logic                       we_o;
  logic [ADW-1:0]             addr_3_o;
  logic [DPW-1:0]             wd_3_o;
  // Hazard query
  logic [ADW-1:0]             rs1_i;
  logic [ADW-1:0]             rs2_i;
  logic                       rs1_pend_o;
  logic                       rs2_pend_o;
  // Status
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic                       empty_o;

  // Producer / issue side
  modport master (
    output alu_valid_i, alu_rd_i, alu_wd_i,
    output lsu_valid_i, lsu_rd_i, lsu_wd_i,
    output rs1_i, rs2_i,
    input  alu_ready_o, lsu_ready_o,
    input  we_o, addr_3_o, wd_3_o,
    input  rs1_pend_o, rs2_pend_o, count_o, empty_o
  );

  // Write-back block side
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_wd_i,
    input  lsu_valid_i, lsu_rd_i, lsu_wd_i,
    input  rs1_i, rs2_i,
    output alu_ready_o, lsu_ready_o,
    output we_o, addr_3_o, wd_3_o,
    output rs1_pend_o, rs2_pend_o, count_o, empty_o
  );

endinterface : rf_writeback_if
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Synchronous in-order FIFO of write-back entries. Exposes per-slot
//           valid bits and destination registers for hazard comparison.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  ADW     = ADW_DEF,
  parameter type ENTRY_T = wb_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  ENTRY_T                     push_data_i,
  input  logic                       pop_i,
  output ENTRY_T                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DEPTH-1:0]           ent_valid_o,
  output logic [ADW-1:0]             ent_rd_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  ENTRY_T          mem_q [DEPTH];
  ENTRY_T          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic            do_push, do_pop;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign ent_valid_o = vld_q;
  assign head_o      = mem_q[rd_ptr_q];

  // Slot destination registers for the pending-write compare
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

  // Next-state: pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    if (do_pop) begin
      rd_ptr_d        = rd_ptr_q + 1'b1;
      vld_d[rd_ptr_q] = 1'b0;
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      vld_d[wr_ptr_q] = 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the queue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Entry storage; contents are qualified by vld_q so no reset is needed
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module  : rf_writeback
// Brief   : Register-file write-side front end. Arbitrates ALU/LSU results
//           (LSU priority), drops x0 writes, buffers in order and drains one
//           write per clock through a registered output stage. Reports
//           pending writes for two hazard query registers.
// Revision: 1.0 - initial release
// ============================================================================
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int ADW   = ADW_DEF,
  parameter int DPW   = DPW_DEF,
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rf_writeback_if.slave  bus
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADW-1:0] rd;
    logic [DPW-1:0] wd;
  } entry_t;

  wb_src_e          src_sel;
  entry_t           in_entry;
  logic             full;
  logic             hs;
  logic             enq;
  logic [CW-1:0]    count;

  entry_t           fifo_head;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic [CW-1:0]    fifo_count;
  logic [DEPTH-1:0] ent_valid;
  logic [ADW-1:0]   ent_rd [DEPTH];

  logic             we_q, we_d;
  entry_t           out_q, out_d;

  logic             rs1_hit, rs2_hit;

  // Occupancy covers the buffered entries plus the one on the output stage
  assign count = fifo_count + CW'(we_q);
  assign full  = (count == CW'(DEPTH));

  // Fixed-priority arbitration and x0 filter; ready never looks at alu_valid_i
  always_comb begin
    bus.lsu_ready_o = !full;
    bus.alu_ready_o = !full && !bus.lsu_valid_i;
    src_sel         = bus.lsu_valid_i ? SRC_LSU : SRC_ALU;
    in_entry.rd     = bus.alu_rd_i;
    in_entry.wd     = bus.alu_wd_i;
    hs              = 1'b0;
    unique case (src_sel)
      SRC_LSU: begin
        in_entry.rd = bus.lsu_rd_i;
        in_entry.wd = bus.lsu_wd_i;
        hs          = bus.lsu_valid_i && !full;
      end
      default: begin
        hs          = bus.alu_valid_i && !full;
      end
    endcase
    enq = hs && (in_entry.rd != '0);
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .ADW     (ADW),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (in_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  // Output stage drains every cycle, so it refills from the FIFO head when
  // entries are waiting, otherwise a new entry bypasses straight into it
  always_comb begin
    fifo_pop  = !fifo_empty;
    fifo_push = enq && !fifo_empty && !fifo_full;
    we_d      = enq || !fifo_empty;
    out_d     = out_q;
    if (!fifo_empty) begin
      out_d = fifo_head;
    end else if (enq) begin
      out_d = in_entry;
    end
  end

  // Output register; address/data hold their last value when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  // Pending-write compare against buffered slots and the output stage
  always_comb begin
    rs1_hit = we_q && (out_q.rd == bus.rs1_i);
    rs2_hit = we_q && (out_q.rd == bus.rs2_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == bus.rs1_i)) rs1_hit = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == bus.rs2_i)) rs2_hit = 1'b1;
    end
    bus.rs1_pend_o = rs1_hit && (bus.rs1_i != '0);
    bus.rs2_pend_o = rs2_hit && (bus.rs2_i != '0);
  end

  assign bus.we_o     = we_q;
  assign bus.addr_3_o = out_q.rd;
  assign bus.wd_3_o   = out_q.wd;
  assign bus.count_o  = count;
  assign bus.empty_o  = (count == '0);

endmodule : rf_writeback
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_writeback
// Brief   : Scoreboard bench for rf_writeback with a register-file stand-in.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_writeback;

  localparam int ADW   = 5;
  localparam int DPW   = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [ADW-1:0] rd;
    logic [DPW-1:0] wd;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  rf_writeback_if #(.ADW(ADW), .DPW(DPW), .DEPTH(DEPTH)) bus ();

  rf_writeback #(.ADW(ADW), .DPW(DPW), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  exp_t           exp_q [$];
  int             m_count = 0;
  logic           mon_en  = 1'b0;
  int             n_vec   = 0;
  int             n_err   = 0;
  logic [DPW-1:0] rf [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file stand-in: commits whatever the write port presents
  always @(posedge clk_i) begin
    if (bus.we_o === 1'b1 && bus.addr_3_o != '0) rf[bus.addr_3_o] <= bus.wd_3_o;
  end

  // Acceptance model: predicts handshakes and queues the expected writes
  initial begin
    logic m_ready;
    exp_t e;
    logic acc;
    forever begin
      @(posedge clk_i);
      if (rst_i) begin
        m_count = 0;
        exp_q.delete();
        mon_en  = 1'b1;
      end else begin
        m_ready = (m_count != DEPTH);
        acc     = 1'b0;
        e       = '0;
        if (bus.lsu_valid_i && m_ready) begin
          acc = 1'b1;
          e   = '{rd: bus.lsu_rd_i, wd: bus.lsu_wd_i};
        end else if (!bus.lsu_valid_i && bus.alu_valid_i && m_ready) begin
          acc = 1'b1;
          e   = '{rd: bus.alu_rd_i, wd: bus.alu_wd_i};
        end
        if (m_count != 0) m_count = m_count - 1;
        if (acc && e.rd != '0) begin
          exp_q.push_back(e);
          m_count = m_count + 1;
        end
      end
    end
  end

  // Monitor: status, readiness, pending flags and in-order write checks
  initial begin
    logic exp_we, p1, p2, exp_lrdy;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        exp_we   = (m_count != 0);
        exp_lrdy = (m_count != DEPTH);
        check("we_o", 64'(bus.we_o), 64'(exp_we));
        check("count_o", 64'(bus.count_o), 64'(m_count));
        check("empty_o", 64'(bus.empty_o), 64'(m_count == 0));
        check("lsu_ready_o", 64'(bus.lsu_ready_o), 64'(exp_lrdy));
        check("alu_ready_o", 64'(bus.alu_ready_o), 64'(exp_lrdy && !bus.lsu_valid_i));
        p1 = 1'b0;
        p2 = 1'b0;
        foreach (exp_q[k]) begin
          if (exp_q[k].rd == bus.rs1_i) p1 = 1'b1;
          if (exp_q[k].rd == bus.rs2_i) p2 = 1'b1;
        end
        if (bus.rs1_i == '0) p1 = 1'b0;
        if (bus.rs2_i == '0) p2 = 1'b0;
        check("rs1_pend_o", 64'(bus.rs1_pend_o), 64'(p1));
        check("rs2_pend_o", 64'(bus.rs2_pend_o), 64'(p2));
        if (exp_we) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("addr_3_o", 64'(bus.addr_3_o), 64'(e.rd));
            check("wd_3_o", 64'(bus.wd_3_o), 64'(e.wd));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
    bus.alu_rd_i    = '0;
    bus.alu_wd_i    = '0;
    bus.lsu_rd_i    = '0;
    bus.lsu_wd_i    = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    // Reset with both producers requesting
    rst_i           = 1'b1;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd3;
    bus.alu_wd_i    = 32'h1111_1111;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = 5'd4;
    bus.lsu_wd_i    = 32'h2222_2222;
    step(2);
    rst_i = 1'b0;
    idle_inputs();
    step(1);
    check("rf3_after_reset", 64'(rf[3]), 64'(0));
    check("rf4_after_reset", 64'(rf[4]), 64'(0));

    // Single ALU write, hazard query on the same register
    bus.rs1_i       = 5'd2;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd2;
    bus.alu_wd_i    = 32'h1234_5678;
    step(1);
    idle_inputs();
    step(3);
    check("rf2_single", 64'(rf[2]), 64'h1234_5678);

    // Contention: LSU first, ALU on the following cycle
    bus.rs1_i       = 5'd5;
    bus.rs2_i       = 5'd6;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = 5'd5;
    bus.lsu_wd_i    = 32'hAAAA_0000;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = 5'd6;
    bus.alu_wd_i    = 32'hBBBB_0000;
    step(1);
    bus.lsu_valid_i = 1'b0;
    step(1);
    idle_inputs();
    step(3);
    check("rf5_contention", 64'(rf[5]), 64'hAAAA_0000);
    check("rf6_contention", 64'(rf[6]), 64'hBBBB_0000);

    // x0 write is handshaken but dropped
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = '0;
    bus.alu_wd_i    = 32'hDEAD_BEEF;
    step(1);
    idle_inputs();
    step(2);

    // Same destination twice: last write wins
    bus.rs1_i       = 5'd3;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = 5'd3;
    bus.lsu_wd_i    = 32'h0000_0001;
    step(1);
    bus.lsu_wd_i    = 32'h0000_0002;
    step(1);
    idle_inputs();
    step(3);
    check("rf3_last_wins", 64'(rf[3]), 64'h0000_0002);

    // Continuous LSU stream to regs 1..7
    bus.rs2_i = 5'd7;
    for (int i = 1; i <= DEPTH + 3; i++) begin
      bus.lsu_valid_i = 1'b1;
      bus.lsu_rd_i    = 5'(i);
      bus.lsu_wd_i    = 32'hC000_0000 | 32'(i);
      step(1);
    end
    idle_inputs();
    step(3);
    for (int i = 1; i <= DEPTH + 3; i++) begin
      check($sformatf("rf%0d_stream", i), 64'(rf[i]), 64'(32'hC000_0000 | 32'(i)));
    end
    check("drained_stream", 64'(exp_q.size()), 64'(0));

    // Reset while writes are in flight: only reg 8 commits
    bus.rs1_i       = 5'd9;
    bus.rs2_i       = 5'd10;
    bus.lsu_valid_i = 1'b1;
    bus.lsu_rd_i    = 5'd8;
    bus.lsu_wd_i    = 32'h8888_8888;
    step(1);
    bus.lsu_rd_i    = 5'd9;
    bus.lsu_wd_i    = 32'h9999_9999;
    rst_i           = 1'b1;
    step(1);
    bus.lsu_rd_i    = 5'd10;
    bus.lsu_wd_i    = 32'hA0A0_A0A0;
    step(1);
    rst_i = 1'b0;
    idle_inputs();
    check("we_after_reset", 64'(bus.we_o), 64'(0));
    step(3);
    check("rf8_mid_reset", 64'(rf[8]), 64'h8888_8888);
    check("rf9_mid_reset", 64'(rf[9]), 64'(0));
    check("rf10_mid_reset", 64'(rf[10]), 64'(0));
    check("drained_final", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rf_writeback
`default_nettype wire
